// File: rtl/fetch_stage.sv
// Fetch stage: owns the fetch PC, drives the BTB lookup and instruction memory
// address, and loads the IF/ID pipeline register.
//
// Build option: define BTB_PREDICT_EN to let BTB hits with word-aligned targets
// steer the next fetch PC. With the macro undefined the BTB inputs are ignored,
// fetch is purely sequential, and the prediction fields of IF/ID stay zero.
//
// Control is a two-state FSM. BOOT spends one cycle parking the PC at RESET_PC
// with an empty IF/ID. RUN handles redirect (highest priority), stall, or a
// normal fetch.

module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,

    output logic [31:0] pc_lookup,
    input  logic        btb_hit,
    input  logic [31:0] btb_target,

    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,

    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic        id_pred_taken,
    output logic [31:0] id_pred_target,

    output logic [15:0] redirect_count,
    output logic [31:0] fetch_count
);

    typedef enum logic [0:0] {
        StBoot,
        StRun
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;

    logic        id_valid_q, id_valid_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic        id_pred_taken_q, id_pred_taken_d;
    logic [31:0] id_pred_target_q, id_pred_target_d;

    logic [15:0] redirect_count_q, redirect_count_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic [31:0] next_seq;
    logic        pred_taken;
    logic [31:0] pred_target;

    // Sequential successor; 32-bit add wraps 0xFFFF_FFFC back to 0.
    assign next_seq = pc_q + 32'd4;

`ifdef BTB_PREDICT_EN
    // A hit with a misaligned target cannot be a real instruction address, so
    // it is treated as a miss rather than fetched.
    always_comb begin
        pred_taken  = btb_hit && (btb_target[1:0] == 2'b00);
        pred_target = pred_taken ? btb_target : 32'h0000_0000;
    end
`else
    logic unused_btb;

    // Prediction disabled: BTB inputs are deliberately left unconsumed.
    always_comb begin
        pred_taken  = 1'b0;
        pred_target = 32'h0000_0000;
        unused_btb  = ^{btb_hit, btb_target};
    end
`endif

    // The fetch PC is exposed combinationally to both the BTB and memory.
    assign pc_lookup = pc_q;
    assign imem_addr = pc_q;

    // Next-state and next IF/ID contents; every target holds unless overridden.
    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        id_valid_d       = id_valid_q;
        id_pc_d          = id_pc_q;
        id_instr_d       = id_instr_q;
        id_pred_taken_d  = id_pred_taken_q;
        id_pred_target_d = id_pred_target_q;
        redirect_count_d = redirect_count_q;
        fetch_count_d    = fetch_count_q;

        case (state_q)
            StBoot: begin
                // Redirects arriving here are dropped; boot always completes.
                state_d    = StRun;
                pc_d       = RESET_PC;
                id_valid_d = 1'b0;
            end

            StRun: begin
                if (redirect_valid) begin
                    // Redirect beats stall: the wrong-path instruction is
                    // squashed even while the pipeline is held.
                    pc_d       = redirect_pc;
                    id_valid_d = 1'b0;
                    if (redirect_count_q != 16'hFFFF) begin
                        redirect_count_d = redirect_count_q + 16'd1;
                    end
                end else if (!stall) begin
                    pc_d             = pred_taken ? pred_target : next_seq;
                    id_valid_d       = 1'b1;
                    id_pc_d          = pc_q;
                    id_instr_d       = imem_rdata;
                    id_pred_taken_d  = pred_taken;
                    id_pred_target_d = pred_target;
                    fetch_count_d    = fetch_count_q + 32'd1;
                end
            end

            default: begin
                state_d = StBoot;
            end
        endcase
    end

    // State, PC, IF/ID and counter registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= StBoot;
            pc_q             <= RESET_PC;
            id_valid_q       <= 1'b0;
            id_pc_q          <= 32'h0000_0000;
            id_instr_q       <= 32'h0000_0000;
            id_pred_taken_q  <= 1'b0;
            id_pred_target_q <= 32'h0000_0000;
            redirect_count_q <= 16'h0000;
            fetch_count_q    <= 32'h0000_0000;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            id_valid_q       <= id_valid_d;
            id_pc_q          <= id_pc_d;
            id_instr_q       <= id_instr_d;
            id_pred_taken_q  <= id_pred_taken_d;
            id_pred_target_q <= id_pred_target_d;
            redirect_count_q <= redirect_count_d;
            fetch_count_q    <= fetch_count_d;
        end
    end

    assign id_valid       = id_valid_q;
    assign id_pc          = id_pc_q;
    assign id_instr       = id_instr_q;
    assign id_pred_taken  = id_pred_taken_q;
    assign id_pred_target = id_pred_target_q;
    assign redirect_count = redirect_count_q;
    assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. A reference model tracks the fetch PC and
// counters; every fetched instruction is pushed to a scoreboard queue and
// popped when it should appear in IF/ID.

module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

`ifdef BTB_PREDICT_EN
    localparam bit PRED_EN = 1'b1;
`else
    localparam bit PRED_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pt;
        logic [31:0] ptgt;
    } entry_t;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] pc_lookup;
    logic        btb_hit;
    logic [31:0] btb_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_pred_taken;
    logic [31:0] id_pred_target;
    logic [15:0] redirect_count;
    logic [31:0] fetch_count;

    int checks;
    int errors;

    // Reference model state
    bit          m_boot;
    logic [31:0] m_pc;
    logic        m_valid;
    logic [15:0] m_rc;
    logic [31:0] m_fc;
    entry_t      cur;
    entry_t      exp_q[$];

    fetch_stage #(
        .RESET_PC(RST_PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .pc_lookup     (pc_lookup),
        .btb_hit       (btb_hit),
        .btb_target    (btb_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_instr      (id_instr),
        .id_pred_taken (id_pred_taken),
        .id_pred_target(id_pred_target),
        .redirect_count(redirect_count),
        .fetch_count   (fetch_count)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // Instruction memory: combinational, address-dependent content.
    assign imem_rdata = instr_of(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_boot  = 1'b1;
        m_pc    = RST_PC;
        m_valid = 1'b0;
        m_rc    = 16'h0;
        m_fc    = 32'h0;
        cur     = '0;
        exp_q.delete();
    endtask

    // Checks the values required while rst is held (asynchronous clear).
    task automatic check_reset_values();
        chk("rst_pc_lookup", pc_lookup, RST_PC);
        chk("rst_imem_addr", imem_addr, RST_PC);
        chk("rst_id_valid", {31'h0, id_valid}, 32'h0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_instr", id_instr, 32'h0);
        chk("rst_id_pred_taken", {31'h0, id_pred_taken}, 32'h0);
        chk("rst_id_pred_target", id_pred_target, 32'h0);
        chk("rst_redirect_count", {16'h0, redirect_count}, 32'h0);
        chk("rst_fetch_count", fetch_count, 32'h0);
    endtask

    // One clock: drive inputs, advance the model, then optionally compare.
    task automatic step(input logic s, input logic r, input logic [31:0] rpc,
                        input logic h, input logic [31:0] tgt, input bit do_chk);
        bit          fetched;
        logic        pred;
        entry_t      e;
        stall          = s;
        redirect_valid = r;
        redirect_pc    = rpc;
        btb_hit        = h;
        btb_target     = tgt;
        fetched        = 1'b0;
        if (m_boot) begin
            m_boot  = 1'b0;
            m_pc    = RST_PC;
            m_valid = 1'b0;
        end else if (r) begin
            m_pc    = rpc;
            m_valid = 1'b0;
            if (m_rc != 16'hFFFF) m_rc = m_rc + 16'd1;
        end else if (!s) begin
            pred    = PRED_EN && h && (tgt[1:0] == 2'b00);
            e.pc    = m_pc;
            e.instr = instr_of(m_pc);
            e.pt    = pred;
            e.ptgt  = pred ? tgt : 32'h0;
            exp_q.push_back(e);
            m_pc    = pred ? tgt : m_pc + 32'd4;
            m_valid = 1'b1;
            m_fc    = m_fc + 32'd1;
            fetched = 1'b1;
        end
        @(posedge clk);
        #1;
        if (fetched) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL scoreboard_empty: observed 0 entries expected 1");
            end else begin
                cur = exp_q.pop_front();
            end
        end
        if (do_chk) begin
            chk("pc_lookup", pc_lookup, m_pc);
            chk("imem_addr", imem_addr, m_pc);
            chk("id_valid", {31'h0, id_valid}, {31'h0, m_valid});
            if (m_valid) begin
                chk("id_pc", id_pc, cur.pc);
                chk("id_instr", id_instr, cur.instr);
                chk("id_pred_taken", {31'h0, id_pred_taken}, {31'h0, cur.pt});
                chk("id_pred_target", id_pred_target, cur.ptgt);
            end
            chk("redirect_count", {16'h0, redirect_count}, {16'h0, m_rc});
            chk("fetch_count", fetch_count, m_fc);
        end
        #1;
    endtask

    task automatic fetch(input logic h, input logic [31:0] tgt);
        step(1'b0, 1'b0, 32'h0, h, tgt, 1'b1);
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        btb_hit        = 1'b0;
        btb_target     = 32'h0;
        rst            = 1'b1;
        model_reset();
        #12;
        check_reset_values();
        @(negedge clk);
        rst = 1'b0;

        // BOOT cycle, then sequential fetch from RESET_PC.
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        fetch(1'b0, 32'h0);
        fetch(1'b0, 32'h0);
        // BTB hit with aligned target at 0x108 (taken only with prediction on).
        fetch(1'b1, 32'h0000_0200);
        chk("fetch_count_after3", fetch_count, 32'd3);
        // Misaligned BTB target is a miss.
        fetch(1'b1, 32'h0000_0202);

        // Redirect wins over stall, leaves a bubble, then fetch resumes there.
        step(1'b1, 1'b1, 32'h0000_0300, 1'b0, 32'h0, 1'b1);
        fetch(1'b0, 32'h0);
        chk("id_pc_after_redirect", id_pc, 32'h0000_0300);

        // Stall held three cycles: everything frozen.
        step(1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0400, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        fetch(1'b0, 32'h0);

        // Misaligned redirect PC is passed through untouched.
        step(1'b0, 1'b1, 32'h0000_0302, 1'b0, 32'h0, 1'b1);

        // PC wrap at the top of the address space.
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1);
        fetch(1'b0, 32'h0);
        chk("pc_wrap", pc_lookup, 32'h0000_0000);
        fetch(1'b0, 32'h0);

        // Mid-operation reset aborts at once; a redirect during BOOT is ignored.
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_reset_values();
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b1, 32'h0000_0500, 1'b0, 32'h0, 1'b1);
        fetch(1'b0, 32'h0);
        chk("first_live_pc", id_pc, RST_PC);

        // Saturation: 0x10000 redirects end at 0xFFFF.
        for (int i = 0; i < 65534; i++) begin
            step(1'b0, 1'b1, 32'h0000_1000, 1'b0, 32'h0, 1'b0);
        end
        step(1'b0, 1'b1, 32'h0000_1000, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h0000_2000, 1'b0, 32'h0, 1'b1);
        chk("redirect_sat", {16'h0, redirect_count}, 32'h0000_FFFF);
        fetch(1'b0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 stall  input  1  hazard unit hold; freeze PC and IF/ID register.
REQ-005 redirect_valid  input  1  EX-stage mispredict/correction request.
REQ-006 redirect_pc  input  32  corrected fetch address from EX.
REQ-007 pc_lookup  output  32  current fetch PC, driven to BTB lookup port.
REQ-008 btb_hit  input  1  BTB hit for pc_lookup.
REQ-009 btb_target  input  32  BTB predicted target for pc_lookup.
REQ-010 imem_addr  output  32  instruction memory address; equals pc_lookup.
REQ-011 imem_rdata  input  32  instruction word, combinational read of imem_addr.
REQ-012 id_valid  output  1  IF/ID register holds a live instruction.
REQ-013 id_pc  output  32  PC of instruction in IF/ID.
REQ-014 id_instr  output  32  instruction word in IF/ID.
REQ-015 id_pred_taken  output  1  fetch predicted taken for this instruction.
REQ-016 id_pred_target  output  32  predicted target carried to EX for compare.
REQ-017 redirect_count  output  16  saturating count of accepted redirects.
REQ-018 fetch_count  output  32  wrapping count of instructions loaded into IF/ID.

Function
REQ-019 FSM states BOOT and RUN; reset enters BOOT; BOOT -> RUN unconditionally on next edge.
REQ-020 In BOOT: pc_f held at RESET_PC, id_valid loaded 0, counters unchanged.
REQ-021 pc_lookup and imem_addr SHALL equal pc_f combinationally at all times.
REQ-022 Prediction valid only when btb_hit=1 and btb_target[1:0]=2'b00; misaligned target treated as miss.
REQ-023 next_seq = pc_f + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-024 RUN, redirect_valid=1 (priority over stall): pc_f <= redirect_pc; id_valid <= 0; other IF/ID fields don't-care; redirect_count += 1 saturating at 16'hFFFF.
REQ-025 RUN, redirect_valid=0, stall=1: pc_f and all IF/ID fields hold; counters hold.
REQ-026 RUN, neither: pc_f <= predicted ? btb_target : next_seq; IF/ID <= {1, pc_f, imem_rdata, predicted, predicted ? btb_target : 32'h0}; fetch_count += 1.
REQ-027 Redirect in BOOT is ignored (BOOT behaviour wins).
REQ-028 Fetch-to-decode latency exactly 1 cycle; one-cycle bubble (id_valid=0) after each redirect.
REQ-029 redirect_pc low bits passed unmodified; alignment is EX's responsibility.

Reset
REQ-030 On rst: state=BOOT, pc_f=RESET_PC, id_valid=0, id_pc=0, id_instr=0, id_pred_taken=0, id_pred_target=0, redirect_count=0, fetch_count=0.
REQ-031 rst asserted mid-operation aborts immediately; first live id_valid=1 appears two edges after rst deassertion (BOOT, then RUN fetch).

Configuration
REQ-032 Macro BTB_PREDICT_EN defined: prediction per REQ-022/REQ-026.
REQ-033 BTB_PREDICT_EN undefined: btb_hit/btb_target ignored, next PC always next_seq, id_pred_taken=0, id_pred_target=0; pc_lookup still driven.

Verification
REQ-034 Reset, RESET_PC=0x100, no BTB hits: id_pc = 0x100, 0x104, 0x108 on successive cycles after BOOT; fetch_count=3.
REQ-035 BTB_PREDICT_EN, btb_hit=1 target 0x200 at pc 0x108: next pc_lookup=0x200; IF/ID shows pc 0x108, pred_taken=1, pred_target=0x200.
REQ-036 btb_hit=1 target 0x202 (misaligned): next pc_lookup=pc+4, id_pred_taken=0.
REQ-037 redirect_valid=1 with stall=1, redirect_pc 0x300: next pc_lookup=0x300, id_valid=0, redirect_count+1; following unstalled cycle id_pc=0x300.
REQ-038 stall held 3 cycles: pc_lookup, id_* and fetch_count unchanged; 0x10000 redirects leave redirect_count=0xFFFF.
REQ-039 pc_f=0xFFFF_FFFC, no hit: next pc_lookup=0x0000_0000.
